// File: rtl/rs_codeword_scheduler_if.sv
// Handshake bundle between the RS message interleaver, the shared encoder core,
// the lane distributor and the codeword scheduler that sits between them.
interface rs_codeword_scheduler_if #(
    parameter int unsigned WIDTH_WORD_RS = 5440,
    parameter int unsigned PARITY_WIDTH  = 300
);
    // Interleaver side
    logic                     i_valid;
    logic [WIDTH_WORD_RS-1:0] word_A;
    logic [WIDTH_WORD_RS-1:0] word_B;
    logic [WIDTH_WORD_RS-1:0] word_C;
    logic [WIDTH_WORD_RS-1:0] word_D;
    logic                     o_ready;
    // Encoder side
    logic [WIDTH_WORD_RS-1:0] enc_msg;
    logic                     enc_valid;
    logic                     enc_ready;
    logic [PARITY_WIDTH-1:0]  enc_parity;
    logic                     enc_par_valid;
    // Distributor side
    logic [WIDTH_WORD_RS-1:0] cw_data;
    logic [1:0]               cw_idx;
    logic                     cw_valid;
    logic                     cw_ready;
    logic                     set_done;
    // Status
    logic                     err_clr;
    logic                     ovf_err;
    logic                     proto_err;

    // Scheduler side
    modport master (
        input  i_valid, word_A, word_B, word_C, word_D,
        input  enc_ready, enc_parity, enc_par_valid,
        input  cw_ready, err_clr,
        output o_ready, enc_msg, enc_valid,
        output cw_data, cw_idx, cw_valid, set_done,
        output ovf_err, proto_err
    );

    // Environment side: interleaver, encoder and distributor
    modport slave (
        output i_valid, word_A, word_B, word_C, word_D,
        output enc_ready, enc_parity, enc_par_valid,
        output cw_ready, err_clr,
        input  o_ready, enc_msg, enc_valid,
        input  cw_data, cw_idx, cw_valid, set_done,
        input  ovf_err, proto_err
    );
endinterface

// File: rtl/rs_codeword_scheduler.sv
// Buffers one A..D message set and time-multiplexes a shared RS(544,514) encoder over it,
// splicing each returned parity into bits [299:0] and emitting the codewords in order.
module rs_codeword_scheduler #(
    parameter int unsigned WIDTH_WORD_RS = 5440,
    parameter int unsigned PARITY_WIDTH  = 300,
    parameter int unsigned N_WORDS       = 4,
    parameter int unsigned PAR_TIMEOUT   = 255
) (
    input logic                     clk,
    input logic                     rst_n,
    rs_codeword_scheduler_if.master bus
);

    localparam logic [1:0] LastIdx = 2'(N_WORDS - 1);
    localparam logic [7:0] TmoLast = 8'(PAR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitPar,
        StEmit
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_idx;
    logic [7:0]               r_tmo;
    logic [WIDTH_WORD_RS-1:0] r_buf [N_WORDS];
    logic [WIDTH_WORD_RS-1:0] r_enc_msg;
    logic                     r_enc_valid;
    logic [WIDTH_WORD_RS-1:0] r_cw_data;
    logic [1:0]               r_cw_idx;
    logic                     r_cw_valid;
    logic                     r_set_done;
    logic                     r_o_ready;
    logic                     r_ovf_err;
    logic                     r_proto_err;

    logic       w_tmo_hit;
    logic       w_stray_par;
    logic       w_ovf_evt;
    logic [1:0] w_idx_nxt;

    assign w_tmo_hit   = (r_state == StWaitPar) && !bus.enc_par_valid && (r_tmo == TmoLast);
    assign w_stray_par = (r_state != StWaitPar) && bus.enc_par_valid;
    assign w_ovf_evt   = bus.i_valid && !r_o_ready;
    assign w_idx_nxt   = r_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= 2'd0;
            r_tmo       <= 8'd0;
            for (int i = 0; i < N_WORDS; i++) begin
                r_buf[i] <= '0;
            end
            r_enc_msg   <= '0;
            r_enc_valid <= 1'b0;
            r_cw_data   <= '0;
            r_cw_idx    <= 2'd0;
            r_cw_valid  <= 1'b0;
            r_set_done  <= 1'b0;
            r_o_ready   <= 1'b1;
            r_ovf_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_set_done <= 1'b0;

            // A new error event in the same cycle as err_clr keeps the flag set
            if (w_ovf_evt) begin
                r_ovf_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (w_tmo_hit || w_stray_par) begin
                r_proto_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_proto_err <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.i_valid) begin
                        r_buf[0]    <= bus.word_A;
                        r_buf[1]    <= bus.word_B;
                        r_buf[2]    <= bus.word_C;
                        r_buf[3]    <= bus.word_D;
                        r_idx       <= 2'd0;
                        r_enc_msg   <= bus.word_A;
                        r_enc_valid <= 1'b1;
                        r_o_ready   <= 1'b0;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.enc_ready) begin
                        r_enc_valid <= 1'b0;
                        r_tmo       <= 8'd0;
                        r_state     <= StWaitPar;
                    end
                end
                StWaitPar: begin
                    if (bus.enc_par_valid) begin
                        r_cw_data  <= {r_buf[r_idx][WIDTH_WORD_RS-1:PARITY_WIDTH], bus.enc_parity};
                        r_cw_idx   <= r_idx;
                        r_cw_valid <= 1'b1;
                        r_state    <= StEmit;
                    end else if (w_tmo_hit) begin
                        // Encoder never answered: emit the word with an all-zero parity field
                        r_cw_data  <= {r_buf[r_idx][WIDTH_WORD_RS-1:PARITY_WIDTH],
                                       {PARITY_WIDTH{1'b0}}};
                        r_cw_idx   <= r_idx;
                        r_cw_valid <= 1'b1;
                        r_state    <= StEmit;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                StEmit: begin
                    if (bus.cw_ready) begin
                        r_cw_valid <= 1'b0;
                        if (r_idx == LastIdx) begin
                            r_set_done <= 1'b1;
                            r_o_ready  <= 1'b1;
                            r_state    <= StIdle;
                        end else begin
                            r_idx       <= w_idx_nxt;
                            r_enc_msg   <= r_buf[w_idx_nxt];
                            r_enc_valid <= 1'b1;
                            r_state     <= StIssue;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_ready   = r_o_ready;
    assign bus.enc_msg   = r_enc_msg;
    assign bus.enc_valid = r_enc_valid;
    assign bus.cw_data   = r_cw_data;
    assign bus.cw_idx    = r_cw_idx;
    assign bus.cw_valid  = r_cw_valid;
    assign bus.set_done  = r_set_done;
    assign bus.ovf_err   = r_ovf_err;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_rs_codeword_scheduler.sv
// Directed bench for rs_codeword_scheduler: a scoreboard queue holds expected codewords
// and a monitor pops and compares them on every downstream handshake.
module tb_rs_codeword_scheduler;

    localparam int unsigned W = 5440;
    localparam int unsigned P = 300;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_done = 0;
    exp_t        sb_q[$];
    bit          drop_par = 1'b0;
    logic [W-1:0] drop_msg = '0;

    rs_codeword_scheduler_if bus ();

    rs_codeword_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk_word(input logic [9:0] s);
        return {544{s}};
    endfunction

    // Stand-in encoder: parity is the top symbol of the message xor 0x155, repeated
    function automatic logic [P-1:0] par_fn(input logic [W-1:0] m);
        logic [9:0] s;
        s = m[W-1 -: 10] ^ 10'h155;
        return {30{s}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got msb %016h lsb %016h, expected msb %016h lsb %016h", name,
                     act[W-1 -: 64], act[63:0], exp[W-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic push_set(input logic [9:0] sa, input logic [9:0] sb, input logic [9:0] sc,
                            input logic [9:0] sd, input bit zero_c);
        logic [W-1:0] w [4];
        exp_t e;
        w[0] = mk_word(sa);
        w[1] = mk_word(sb);
        w[2] = mk_word(sc);
        w[3] = mk_word(sd);
        for (int i = 0; i < 4; i++) begin
            e.idx  = 2'(i);
            e.data = {w[i][W-1:P], (zero_c && i == 2) ? {P{1'b0}} : par_fn(w[i])};
            sb_q.push_back(e);
        end
    endtask

    task automatic send_set(input logic [9:0] sa, input logic [9:0] sb, input logic [9:0] sc,
                            input logic [9:0] sd, output int unsigned t);
        @(posedge clk); #1;
        bus.word_A  = mk_word(sa);
        bus.word_B  = mk_word(sb);
        bus.word_C  = mk_word(sc);
        bus.word_D  = mk_word(sd);
        bus.i_valid = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (n_acc < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(n_acc), 64'(n));
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.set_done) n_done++;
        if (rst_n && bus.cw_valid && bus.cw_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cw_unexpected: got codeword idx %0d, expected none", bus.cw_idx);
            end else begin
                e = sb_q.pop_front();
                chk("cw_idx", 64'(bus.cw_idx), 64'(e.idx));
                chk_w("cw_data", bus.cw_data, e.data);
            end
            n_acc++;
        end
    end

    // Encoder model: parity one cycle after each accepted message
    initial begin
        logic [W-1:0] m;
        forever begin
            @(negedge clk);
            if (rst_n && bus.enc_valid && bus.enc_ready &&
                !(drop_par && bus.enc_msg == drop_msg)) begin
                m = bus.enc_msg;
                @(posedge clk); #1;
                bus.enc_par_valid = 1'b1;
                bus.enc_parity    = par_fn(m);
                @(posedge clk); #1;
                bus.enc_par_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  t0, t_enc, t_cw, t_done;
        int           base, k, done_hi, done0;
        logic [W-1:0] cap_d;
        logic [1:0]   cap_i;
        bit           stable, saw, found;

        bus.i_valid       = 1'b0;
        bus.word_A        = '0;
        bus.word_B        = '0;
        bus.word_C        = '0;
        bus.word_D        = '0;
        bus.enc_ready     = 1'b0;
        bus.enc_parity    = '0;
        bus.enc_par_valid = 1'b0;
        bus.cw_ready      = 1'b0;
        bus.err_clr       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_enc_valid", 64'(bus.enc_valid), 64'd0);
        chk("rst_cw_valid", 64'(bus.cw_valid), 64'd0);
        chk("rst_set_done", 64'(bus.set_done), 64'd0);
        chk("rst_errs", 64'({bus.ovf_err, bus.proto_err}), 64'd0);
        chk_w("rst_cw_data", bus.cw_data, '0);
        chk_w("rst_enc_msg", bus.enc_msg, '0);
        rst_n         = 1'b1;
        bus.enc_ready = 1'b1;
        bus.cw_ready  = 1'b1;

        // 1: one full set, everything ready; check latencies
        push_set(10'h001, 10'h0F0, 10'h2AA, 10'h3FF, 1'b0);
        send_set(10'h001, 10'h0F0, 10'h2AA, 10'h3FF, t0);
        t_enc = 0; t_cw = 0; t_done = 0; done_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.enc_valid && t_enc == 0) t_enc = cyc;
            if (bus.cw_valid && t_cw == 0) t_cw = cyc;
            if (bus.set_done && t_done == 0) t_done = cyc;
            if (bus.set_done) done_hi++;
        end
        chk("lat_enc_valid", 64'(t_enc - t0), 64'd1);
        chk("lat_cw_valid", 64'(t_cw - t0), 64'd3);
        chk("lat_set_done", 64'(t_done - t0), 64'd13);
        chk("set_done_width", 64'(done_hi), 64'd1);
        chk("set1_count", 64'(n_acc), 64'd4);
        chk("set1_o_ready", 64'(bus.o_ready), 64'd1);

        // 2: downstream stall while idx1 is presented
        base = n_acc;
        push_set(10'h010, 10'h020, 10'h030, 10'h040, 1'b0);
        send_set(10'h010, 10'h020, 10'h030, 10'h040, t0);
        wait_acc(base + 1, 30, "set2_acc_a");
        @(posedge clk); #1;
        bus.cw_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = bus.cw_valid;
        end
        chk("stall_cw_seen", 64'(found), 64'd1);
        cap_d = bus.cw_data;
        cap_i = bus.cw_idx;
        stable = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cw_data !== cap_d || bus.cw_idx !== cap_i || !bus.cw_valid) stable = 1'b0;
            if (bus.enc_valid) saw = 1'b1;
        end
        chk("stall_idx", 64'(cap_i), 64'd1);
        chk("stall_stable", 64'(stable), 64'd1);
        chk("stall_no_enc_valid", 64'(saw), 64'd0);
        @(posedge clk); #1;
        bus.cw_ready = 1'b1;
        wait_acc(base + 4, 40, "set2_acc");

        // 3: encoder stall on A, overflow set offered meanwhile
        base = n_acc;
        bus.enc_ready = 1'b0;
        push_set(10'h111, 10'h122, 10'h133, 10'h144, 1'b0);
        send_set(10'h111, 10'h122, 10'h133, 10'h144, t0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = bus.enc_valid;
        end
        chk("issue_enc_valid", 64'(found), 64'd1);
        cap_d = bus.enc_msg;
        chk_w("issue_enc_msg", cap_d, mk_word(10'h111));
        send_set(10'h3C3, 10'h3C3, 10'h3C3, 10'h3C3, t0);
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.enc_msg !== cap_d || !bus.enc_valid) stable = 1'b0;
        end
        chk("issue_stable", 64'(stable), 64'd1);
        chk("ovf_err_set", 64'(bus.ovf_err), 64'd1);
        @(posedge clk); #1;
        bus.enc_ready = 1'b1;
        wait_acc(base + 4, 40, "set3_acc");
        pulse_clr();
        @(negedge clk);
        chk("ovf_err_clr", 64'(bus.ovf_err), 64'd0);

        // 4: no parity for word C -> timeout
        base = n_acc;
        drop_par = 1'b1;
        drop_msg = mk_word(10'h203);
        push_set(10'h201, 10'h202, 10'h203, 10'h204, 1'b1);
        send_set(10'h201, 10'h202, 10'h203, 10'h204, t0);
        wait_acc(base + 2, 30, "set4_acc_ab");
        k = 0;
        found = 1'b0;
        while (!found && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 200) chk("proto_err_early", 64'(bus.proto_err), 64'd0);
            found = bus.cw_valid;
        end
        chk("tmo_window", 64'(k >= 250 && k <= 262), 64'd1);
        chk("proto_err_tmo", 64'(bus.proto_err), 64'd1);
        wait_acc(base + 4, 40, "set4_acc");
        drop_par = 1'b0;
        pulse_clr();
        @(negedge clk);
        chk("proto_err_clr4", 64'(bus.proto_err), 64'd0);

        // 5: stray parity in IDLE, clear, clear racing a new event
        @(posedge clk); #1;
        bus.enc_par_valid = 1'b1;
        @(posedge clk); #1;
        bus.enc_par_valid = 1'b0;
        @(negedge clk);
        chk("stray_proto_err", 64'(bus.proto_err), 64'd1);
        chk("stray_o_ready", 64'(bus.o_ready), 64'd1);
        pulse_clr();
        @(negedge clk);
        chk("clr_proto_err", 64'(bus.proto_err), 64'd0);
        @(posedge clk); #1;
        bus.err_clr       = 1'b1;
        bus.enc_par_valid = 1'b1;
        @(posedge clk); #1;
        bus.err_clr       = 1'b0;
        bus.enc_par_valid = 1'b0;
        @(negedge clk);
        chk("clr_vs_event", 64'(bus.proto_err), 64'd1);
        pulse_clr();
        @(negedge clk);
        chk("clr_again", 64'(bus.proto_err), 64'd0);

        // 6: reset while waiting for parity of A
        base = n_acc;
        drop_par = 1'b1;
        drop_msg = mk_word(10'h055);
        send_set(10'h055, 10'h066, 10'h077, 10'h088, t0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = !bus.enc_valid && !bus.o_ready;
        end
        chk("set6_waitpar", 64'(found), 64'd1);
        repeat (3) @(negedge clk);
        done0 = n_done;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_ready", 64'(bus.o_ready), 64'd1);
        chk("midrst_valids", 64'({bus.enc_valid, bus.cw_valid, bus.set_done}), 64'd0);
        chk("midrst_errs", 64'({bus.ovf_err, bus.proto_err}), 64'd0);
        chk_w("midrst_enc_msg", bus.enc_msg, '0);
        chk_w("midrst_cw_data", bus.cw_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drop_par = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.cw_valid || bus.set_done || bus.enc_valid) saw = 1'b1;
        end
        chk("postrst_quiet", 64'(saw), 64'd0);
        chk("postrst_no_done", 64'(n_done), 64'(done0));
        push_set(10'h301, 10'h302, 10'h303, 10'h304, 1'b0);
        send_set(10'h301, 10'h302, 10'h303, 10'h304, t0);
        wait_acc(base + 4, 40, "set7_acc");
        repeat (3) @(negedge clk);
        chk("set7_done", 64'(n_done), 64'(done0 + 1));
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
